ram_sdp_be: RTL and testbench

Parametrised simple-dual-port RAM: one write port with byte enables, one read port with a configurable read latency and read-valid flag. A built-in clear engine zeroes the whole array after reset and on request. It replaces the fixed-width single-cycle RAM in datapaths that need partial-word writes, deterministic contents after reset, and a pipelined read path.

---
 rtl/ram_sdp_be.sv | 146 ++++++++++++++
 tb/tb_ram_sdp_be.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-enable writes, 1- or 2-cycle registered read
// path and a clear engine that zeroes the array after reset and on request.
module ram_sdp_be #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RD_LATENCY = 1,
  parameter bit          RDW_MODE   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    wr_enb,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_enb,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_accept_c;
  logic                    rd_accept_c;
  logic [DATA_WIDTH-1:0]   wr_mask_c;
  logic [DATA_WIDTH-1:0]   rd_word_c;

  logic                    rd1_valid;
  logic [DATA_WIDTH-1:0]   rd1_data;

  // Port qualification; clr in the same cycle drops the write but not the read.
  always_comb begin
    wr_accept_c = 1'b0;
    rd_accept_c = 1'b0;
    wr_mask_c   = '0;
    rd_word_c   = mem[rd_addr];
    if (state == ST_IDLE) begin
      wr_accept_c = wr_enb && !clr;
      rd_accept_c = rd_enb;
    end
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      wr_mask_c[8*i +: 8] = {8{wr_be[i]}};
    end
    if (RDW_MODE && wr_accept_c && (wr_addr == rd_addr)) begin
      rd_word_c = (rd_word_c & ~wr_mask_c) | (wr_data & wr_mask_c);
    end
  end

  // Clear engine: walks every address once, then hands the ports to the user.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state   <= ST_CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          busy    <= 1'b1;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // Storage array has no reset; the clear engine provides its initial contents.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_accept_c) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // First read register; data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_valid <= 1'b0;
      rd1_data  <= '0;
    end else begin
      rd1_valid <= rd_accept_c;
      if (rd_accept_c) begin
        rd1_data <= rd_word_c;
      end
    end
  end

  generate
    if (RD_LATENCY >= 2) begin : g_lat2
      logic                  rd2_valid;
      logic [DATA_WIDTH-1:0] rd2_data;

      // Extra output register for timing-critical consumers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd2_valid <= 1'b0;
          rd2_data  <= '0;
        end else begin
          rd2_valid <= rd1_valid;
          if (rd1_valid) begin
            rd2_data <= rd1_data;
          end
        end
      end

      assign rd_valid = rd2_valid;
      assign rd_data  = rd2_data;
    end else begin : g_lat1
      assign rd_valid = rd1_valid;
      assign rd_data  = rd1_data;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// Scoreboard bench for ram_sdp_be: one instance with latency 1 / old-data RDW,
// one with latency 2 / new-data RDW, both driven by the same directed steps.
module tb_ram_sdp_be;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        wr_enb = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_enb = 1'b0;
  logic [3:0]  rd_addr = '0;

  logic        busy_a, busy_b;
  logic        rd_valid_a, rd_valid_b;
  logic [31:0] rd_data_a, rd_data_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] last_d [2];
  logic [31:0] m_mem [16];
  logic        m_busy;
  logic [3:0]  m_cnt;

  ram_sdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(1), .RDW_MODE(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
  );

  ram_sdp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2), .RDW_MODE(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Compare one instance's read port against the head of its scoreboard.
  task automatic mon(input int id, input logic v, input logic [31:0] d);
    exp_t e;
    logic have;
    have = (id == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
    if (have) e = (id == 0) ? q_a[0] : q_b[0];
    if (v) begin
      chk($sformatf("rd_valid_expected[%0d]", id), 32'(have), 32'd1);
      if (have) begin
        if (id == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
        chk($sformatf("rd_data[%0d]", id), d, e.data);
        chk($sformatf("rd_latency[%0d]", id), 32'(cyc), 32'(e.due));
      end
      last_d[id] = d;
    end else begin
      chk($sformatf("rd_hold[%0d]", id), d, last_d[id]);
      if (have && e.due <= cyc) begin
        chk($sformatf("rd_valid_missing[%0d]", id), 32'(v), 32'd1);
        if (id == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rd_valid_a, rd_data_a);
    mon(1, rd_valid_b, rd_data_b);
  end

  // Present one cycle of stimulus, update the reference model, then move to the next cycle.
  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [3:0] ra,
                       input logic c);
    logic [31:0] old, mask, merged;
    exp_t e;
    wr_enb = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_enb = re; rd_addr = ra; clr = c;
    chk("busy[0]", 32'(busy_a), 32'(m_busy));
    chk("busy[1]", 32'(busy_b), 32'(m_busy));
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
    if (!m_busy && re) begin
      old = m_mem[ra];
      merged = (we && !c && wa == ra) ? ((old & ~mask) | (wd & mask)) : old;
      e.data = old;    e.due = cyc + 1; q_a.push_back(e);
      e.data = merged; e.due = cyc + 2; q_b.push_back(e);
    end
    if (m_busy) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == 4'd15) m_busy = 1'b0;
      m_cnt = m_cnt + 4'd1;
    end else if (c) begin
      m_busy = 1'b1;
      m_cnt = '0;
    end else if (we) begin
      m_mem[wa] = (m_mem[wa] & ~mask) | (wd & mask);
    end
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(1'b1, a, d, be, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a, 1'b0);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input int n);
    wr_enb = 1'b0; rd_enb = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_rd_data[0]", rd_data_a, 32'd0);
    chk("rst_rd_data[1]", rd_data_b, 32'd0);
    chk("rst_rd_valid[0]", 32'(rd_valid_a), 32'd0);
    chk("rst_rd_valid[1]", 32'(rd_valid_b), 32'd0);
    chk("rst_busy[0]", 32'(busy_a), 32'd1);
    q_a.delete(); q_b.delete();
    last_d[0] = '0; last_d[1] = '0;
    m_busy = 1'b1; m_cnt = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    repeat (n) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    last_d[0] = '0; last_d[1] = '0;
    @(negedge clk); #1;

    // Reset, initial clear, then every address reads zero
    do_reset(3);
    idle(18);
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle(3);

    // Byte-enable merge
    wr(4'd5, 32'hAABBCCDD, 4'b1111);
    wr(4'd5, 32'h11223344, 4'b0101);
    wr(4'd6, 32'h55555555, 4'b0000);
    rd(4'd5);
    rd(4'd6);
    idle(3);

    // Back-to-back reads, constant latency
    for (int i = 1; i <= 4; i++) wr(4'(i), 32'(i), 4'b1111);
    for (int i = 1; i <= 4; i++) rd(4'(i));
    idle(3);

    // Read during write to the same address, then read after
    wr(4'd7, 32'h12345678, 4'b1111);
    drive(1'b1, 4'd7, 32'hFFFFFFFF, 4'b0011, 1'b1, 4'd7, 1'b0);
    rd(4'd7);
    idle(3);

    // clr collides with a write; the read in that cycle is still served
    drive(1'b1, 4'd3, 32'hDEADBEEF, 4'b1111, 1'b1, 4'd3, 1'b1);
    for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 32'hBAD0BAD0, 4'b1111, 1'b1, 4'(i), 1'b0);
    rd(4'd3);
    rd(4'd7);
    idle(3);

    // Reset in the middle of a clear
    wr(4'd9, 32'hCAFEF00D, 4'b1111);
    rd(4'd9);
    idle(3);
    drive(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b1);
    idle(7);
    do_reset(1);
    idle(18);
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle(3);

    // Random mix on a few addresses to provoke read-during-write collisions
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 1'b0);
    end
    idle(4);

    chk("drain[0]", 32'(q_a.size()), 32'd0);
    chk("drain[1]", 32'(q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
